// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module : dmem_arb_pkg
// Brief  : Shared types and sizes for the data-memory arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

   localparam int DMEM_ADDR_W = 12;
   localparam int DMEM_DATA_W = 32;

   typedef enum logic {
      ARB_NORMAL = 1'b0,
      ARB_FORCE  = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_PIPE = 2'd1,
      OWN_HOST = 2'd2
   } owner_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_if.sv
// ============================================================================
// Module : dmem_arb_if
// Brief  : Pipeline, host-loader and memory-macro signals around the arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arb_if
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W
);

   logic              pipe_req;
   logic              pipe_we;
   logic [ADDR_W-1:0] pipe_addr;
   logic [DATA_W-1:0] pipe_wdata;
   logic [DATA_W-1:0] pipe_rdata;
   logic              pipe_stall;

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_gnt;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side
   modport slave (
      input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
      output pipe_rdata, pipe_stall,
      input  host_req, host_we, host_addr, host_wdata,
      output host_gnt, host_rvalid, host_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Environment side: MEM stage, host loader and memory macro
   modport master (
      output pipe_req, pipe_we, pipe_addr, pipe_wdata,
      input  pipe_rdata, pipe_stall,
      output host_req, host_we, host_addr, host_wdata,
      input  host_gnt, host_rvalid, host_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

`default_nettype wire

// File: rtl/dmem_starve_cnt.sv
// ============================================================================
// Module : dmem_starve_cnt
// Brief  : Counts consecutive denied host cycles; flags the terminal count.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_starve_cnt
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic en_i,
   input  logic deny_i,
   output logic force_req_o
);

   localparam logic [7:0] C_TERM = 8'(STARVE_MAX - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign force_req_o = en_i && deny_i && (cnt_q == C_TERM);

   // Terminal count wraps to zero as the FORCE window is entered
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         if (!deny_i || (cnt_q == C_TERM)) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : Shares the data memory between the MEM stage and the host loader,
//          with starvation-forced host grants. DMEM_ARB_BURST_EN enables
//          multi-beat forced windows of up to BURST_MAX beats.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 8,
   parameter int unsigned BURST_MAX  = 4
) (
   input  logic      clk_i,
   input  logic      rst_n_i,
   dmem_arb_if.slave bus
);

   if ((STARVE_MAX < 1) || (STARVE_MAX > 255) || (BURST_MAX < 1) || (BURST_MAX > 16)) begin : g_param_check
      $error("dmem_arbiter: STARVE_MAX or BURST_MAX out of range");
   end

   arb_state_t state_q;
   arb_state_t state_d;
   owner_t     owner;
   logic       host_gnt;
   logic       rvalid_q;
   logic       force_req;

`ifdef DMEM_ARB_BURST_EN
   localparam int          BEAT_W    = $clog2(BURST_MAX + 1);
   localparam logic [BEAT_W-1:0] C_BEAT_LAST = BEAT_W'(BURST_MAX - 1);
   logic [BEAT_W-1:0] beat_q;
   logic [BEAT_W-1:0] beat_d;
`endif

   // Everything combinational is held inactive while reset is asserted
   always_comb begin
      owner = OWN_NONE;
      if (rst_n_i) begin
         case (state_q)
            ARB_NORMAL: begin
               if (bus.pipe_req) begin
                  owner = OWN_PIPE;
               end else if (bus.host_req) begin
                  owner = OWN_HOST;
               end
            end
            ARB_FORCE: begin
               if (bus.host_req) begin
                  owner = OWN_HOST;
               end
            end
            default: owner = OWN_NONE;
         endcase
      end
   end

   assign host_gnt = (owner == OWN_HOST);

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (owner)
         OWN_PIPE: begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.pipe_we;
            bus.mem_addr  = bus.pipe_addr;
            bus.mem_wdata = bus.pipe_wdata;
         end
         OWN_HOST: begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.host_we;
            bus.mem_addr  = bus.host_addr;
            bus.mem_wdata = bus.host_wdata;
         end
         default: ;
      endcase
   end

   assign bus.host_gnt    = host_gnt;
   assign bus.host_rvalid = rvalid_q;
   assign bus.pipe_stall  = rst_n_i && (state_q == ARB_FORCE);
   assign bus.pipe_rdata  = rst_n_i ? bus.mem_rdata : '0;
   assign bus.host_rdata  = rst_n_i ? bus.mem_rdata : '0;

   dmem_starve_cnt #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_cnt (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .en_i        (state_q == ARB_NORMAL),
      .deny_i      (bus.host_req && !host_gnt),
      .force_req_o (force_req)
   );

   always_comb begin
      state_d = state_q;
`ifdef DMEM_ARB_BURST_EN
      beat_d  = beat_q;
`endif
      case (state_q)
         ARB_NORMAL: begin
            if (force_req) begin
               state_d = ARB_FORCE;
            end
         end
         ARB_FORCE: begin
`ifdef DMEM_ARB_BURST_EN
            // A dropped request ends the window as well as the last beat
            if (!bus.host_req || (beat_q == C_BEAT_LAST)) begin
               state_d = ARB_NORMAL;
               beat_d  = '0;
            end else begin
               beat_d  = beat_q + BEAT_W'(1);
            end
`else
            state_d = ARB_NORMAL;
`endif
         end
         default: state_d = ARB_NORMAL;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ARB_NORMAL;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= host_gnt && !bus.host_we;
      end
   end

`ifdef DMEM_ARB_BURST_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         beat_q <= '0;
      end else begin
         beat_q <= beat_d;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Directed vector bench for dmem_arbiter (STARVE_MAX=4, BURST_MAX=4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

   typedef struct {
      logic        preq;
      logic        pwe;
      logic [11:0] paddr;
      logic [31:0] pwd;
      logic        hreq;
      logic        hwe;
      logic [11:0] haddr;
      logic [31:0] hwd;
      logic        gnt;
      logic        stall;
      logic        men;
      logic        mwe;
      logic [11:0] maddr;
      logic        rv;
      logic        chk_rd;
      logic [31:0] hrd;
   } vec_t;

   logic clk_i;
   logic rst_n_i;
   int   n_vec;
   int   n_err;

   dmem_arb_if bus ();

   dmem_arbiter #(
      .STARVE_MAX (4),
      .BURST_MAX  (4)
   ) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Memory macro model: unwritten words read back as a fixed address pattern
   logic [31:0]   mem [0:4095];
   logic [4095:0] written;
   logic          mem_clr;
   logic [31:0]   rd_q;

   function automatic logic [31:0] pat(input logic [11:0] a);
      return 32'hC0DE_0000 | {20'h0, a};
   endfunction

   always @(posedge clk_i) begin
      if (mem_clr) begin
         written <= '0;
         rd_q    <= '0;
      end else if (bus.mem_en) begin
         if (bus.mem_we) begin
            mem[bus.mem_addr]     <= bus.mem_wdata;
            written[bus.mem_addr] <= 1'b1;
         end else begin
            rd_q <= written[bus.mem_addr] ? mem[bus.mem_addr] : pat(bus.mem_addr);
         end
      end
   end
   assign bus.mem_rdata = rd_q;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic preq, input logic pwe, input logic [11:0] paddr, input logic [31:0] pwd,
                        input logic hreq, input logic hwe, input logic [11:0] haddr, input logic [31:0] hwd);
      bus.pipe_req   = preq;
      bus.pipe_we    = pwe;
      bus.pipe_addr  = paddr;
      bus.pipe_wdata = pwd;
      bus.host_req   = hreq;
      bus.host_we    = hwe;
      bus.host_addr  = haddr;
      bus.host_wdata = hwd;
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      next_cycle();
      rst_n_i = 1'b0;
      drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
      next_cycle();
      next_cycle();
      rst_n_i = 1'b1;
   endtask

   function automatic vec_t mk(input logic preq, input logic pwe, input logic [11:0] paddr, input logic [31:0] pwd,
                               input logic hreq, input logic hwe, input logic [11:0] haddr, input logic [31:0] hwd,
                               input logic gnt, input logic stall, input logic men, input logic mwe,
                               input logic [11:0] maddr, input logic rv, input logic chk_rd, input logic [31:0] hrd);
      vec_t v;
      v.preq = preq;  v.pwe = pwe;  v.paddr = paddr;  v.pwd = pwd;
      v.hreq = hreq;  v.hwe = hwe;  v.haddr = haddr;  v.hwd = hwd;
      v.gnt = gnt;    v.stall = stall;  v.men = men;  v.mwe = mwe;
      v.maddr = maddr;  v.rv = rv;  v.chk_rd = chk_rd;  v.hrd = hrd;
      return v;
   endfunction

   vec_t tv [21];

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst_n_i = 1'b0;
      mem_clr = 1'b1;
      drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h010, 32'h0);

      // Sequential cycle table; each row is one clock
      tv[0] = mk(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 32'h0);
      tv[1] = mk(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'h010, 32'hA5A5A5A5,
                 1'b1, 1'b0, 1'b1, 1'b1, 12'h010, 1'b0, 1'b0, 32'h0);
      tv[2] = mk(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h010, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b0, 12'h010, 1'b0, 1'b0, 32'h0);
      tv[3] = mk(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 32'hA5A5A5A5);
      tv[4] = mk(1'b1, 1'b1, 12'h020, 32'h12345678, 1'b0, 1'b0, 12'h000, 32'h0,
                 1'b0, 1'b0, 1'b1, 1'b1, 12'h020, 1'b0, 1'b0, 32'h0);
      for (int i = 5; i < 9; i++) begin
         tv[i] = mk(1'b1, 1'b0, 12'h040, 32'h0, 1'b1, 1'b0, 12'h030, 32'h0,
                    1'b0, 1'b0, 1'b1, 1'b0, 12'h040, 1'b0, 1'b0, 32'h0);
      end
      tv[9] = mk(1'b1, 1'b0, 12'h040, 32'h0, 1'b1, 1'b0, 12'h030, 32'h0,
                 1'b1, 1'b1, 1'b1, 1'b0, 12'h030, 1'b0, 1'b0, 32'h0);
`ifdef DMEM_ARB_BURST_EN
      // Window still open; the dropped request closes it with a stalled idle cycle
      tv[10] = mk(1'b1, 1'b0, 12'h040, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
                  1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 32'hC0DE0030);
`else
      tv[10] = mk(1'b1, 1'b0, 12'h040, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
                  1'b0, 1'b0, 1'b1, 1'b0, 12'h040, 1'b1, 1'b1, 32'hC0DE0030);
`endif
      for (int i = 11; i < 15; i++) begin
         tv[i] = mk(1'b1, 1'b0, 12'h041, 32'h0, 1'b1, 1'b1, 12'h050, 32'hDEADBEEF,
                    1'b0, 1'b0, 1'b1, 1'b0, 12'h041, 1'b0, 1'b0, 32'h0);
      end
      tv[15] = mk(1'b1, 1'b0, 12'h041, 32'h0, 1'b0, 1'b1, 12'h050, 32'hDEADBEEF,
                  1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 32'h0);
      for (int i = 16; i < 20; i++) begin
         tv[i] = mk(1'b1, 1'b0, 12'h041, 32'h0, 1'b1, 1'b1, 12'h050, 32'hDEADBEEF,
                    1'b0, 1'b0, 1'b1, 1'b0, 12'h041, 1'b0, 1'b0, 32'h0);
      end
      tv[20] = mk(1'b1, 1'b0, 12'h041, 32'h0, 1'b1, 1'b1, 12'h050, 32'hDEADBEEF,
                  1'b1, 1'b1, 1'b1, 1'b1, 12'h050, 1'b0, 1'b0, 32'h0);

      // Reset state with a pending host request
      #2;
      chk("rst gnt", 32'(bus.host_gnt), 32'h0);
      chk("rst mem_en", 32'(bus.mem_en), 32'h0);
      chk("rst mem_addr", 32'(bus.mem_addr), 32'h0);
      chk("rst rvalid", 32'(bus.host_rvalid), 32'h0);
      next_cycle();
      mem_clr = 1'b0;
      rst_n_i = 1'b1;

      for (int i = 0; i < 21; i++) begin
         drive(tv[i].preq, tv[i].pwe, tv[i].paddr, tv[i].pwd, tv[i].hreq, tv[i].hwe, tv[i].haddr, tv[i].hwd);
         @(negedge clk_i);
         chk($sformatf("r%0d gnt", i), 32'(bus.host_gnt), 32'(tv[i].gnt));
         chk($sformatf("r%0d stall", i), 32'(bus.pipe_stall), 32'(tv[i].stall));
         chk($sformatf("r%0d mem_en", i), 32'(bus.mem_en), 32'(tv[i].men));
         chk($sformatf("r%0d mem_we", i), 32'(bus.mem_we), 32'(tv[i].mwe));
         chk($sformatf("r%0d mem_addr", i), 32'(bus.mem_addr), 32'(tv[i].maddr));
         chk($sformatf("r%0d rvalid", i), 32'(bus.host_rvalid), 32'(tv[i].rv));
         if (tv[i].chk_rd) begin
            chk($sformatf("r%0d host_rdata", i), bus.host_rdata, tv[i].hrd);
         end
         next_cycle();
      end

      // Back-to-back pipeline loads
      do_reset();
      drive(1'b1, 1'b0, 12'h001, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
      @(negedge clk_i);
      chk("ld1 mem_addr", 32'(bus.mem_addr), 32'h001);
      chk("ld1 stall", 32'(bus.pipe_stall), 32'h0);
      next_cycle();
      drive(1'b1, 1'b0, 12'h002, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
      @(negedge clk_i);
      chk("ld1 rdata", bus.pipe_rdata, pat(12'h001));
      chk("ld2 stall", 32'(bus.pipe_stall), 32'h0);
      next_cycle();
      drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
      @(negedge clk_i);
      chk("ld2 rdata", bus.pipe_rdata, pat(12'h002));

      // Host held through and past a forced window
      do_reset();
      drive(1'b1, 1'b0, 12'h060, 32'h0, 1'b1, 1'b0, 12'h070, 32'h0);
      for (int c = 0; c < 10; c++) begin
         logic eg;
`ifdef DMEM_ARB_BURST_EN
         eg = (c >= 4) && (c <= 7);
`else
         eg = (c == 4) || (c == 9);
`endif
         @(negedge clk_i);
         chk($sformatf("burst c%0d gnt", c), 32'(bus.host_gnt), 32'(eg));
         chk($sformatf("burst c%0d stall", c), 32'(bus.pipe_stall), 32'(eg));
         chk($sformatf("burst c%0d mem_addr", c), 32'(bus.mem_addr), eg ? 32'h070 : 32'h060);
         next_cycle();
      end

      // Reset while a forced host read is in flight
      do_reset();
      drive(1'b1, 1'b0, 12'h060, 32'h0, 1'b1, 1'b0, 12'h010, 32'h0);
      for (int c = 0; c < 4; c++) next_cycle();
      @(negedge clk_i);
      chk("mid gnt", 32'(bus.host_gnt), 32'h1);
      chk("mid stall", 32'(bus.pipe_stall), 32'h1);
      next_cycle();
      rst_n_i = 1'b0;
      @(negedge clk_i);
      chk("mid rst rvalid", 32'(bus.host_rvalid), 32'h0);
      chk("mid rst mem_en", 32'(bus.mem_en), 32'h0);
      chk("mid rst mem_addr", 32'(bus.mem_addr), 32'h0);
      chk("mid rst stall", 32'(bus.pipe_stall), 32'h0);
      next_cycle();
      drive(1'b1, 1'b0, 12'h060, 32'h0, 1'b1, 1'b0, 12'h010, 32'h0);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      chk("post rst stall", 32'(bus.pipe_stall), 32'h0);
      chk("post rst gnt", 32'(bus.host_gnt), 32'h0);
      chk("post rst rvalid", 32'(bus.host_rvalid), 32'h0);
      next_cycle();
      @(negedge clk_i);
      chk("post rst c1 gnt", 32'(bus.host_gnt), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
